vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 160, meaning 32-bit framebuffer words per scanline (4 pixels/word, 640 pixels).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning framebuffer word-address width.
REQ-003 SHALL have parameter FB_BASE, default 0, meaning framebuffer word address of line 0.
REQ-004 SHALL have parameter CPU_SLOT, default 4, meaning that during a fetch, every CPU_SLOT-th cycle may go to the CPU.
REQ-005 pixelClock  in  1  clock; reset  in  1  synchronous, active-high reset on pixelClock.
REQ-006 line_req  in  1  one-cycle pulse requesting a prefetch of one scanline; line_num  in  10  line index, sampled with line_req.
REQ-007 cpu_req  in  1; cpu_we  in  1; cpu_addr  in  ADDR_W; cpu_wdata  in  32  CPU access request, held until cpu_ack.
REQ-008 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  32  read data, valid with cpu_ack.
REQ-009 mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  32; mem_rdata  in  32  single-port RAM, read data valid exactly 1 cycle after a mem_en & ~mem_we cycle.
REQ-010 lb_we  out  1; lb_addr  out  9 ({bank, word[7:0]}); lb_wdata  out  32  double-buffered line-buffer write port.
REQ-011 fetch_busy  out  1  line fetch in progress; underrun  out  1  sticky overrun flag.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH and CPU; at most one memory access (mem_en) SHALL be issued per cycle.
REQ-013 IDLE: line_req -> FETCH, word counter = 0, line base = FB_BASE + line_num*WORDS_PER_LINE (ADDR_W wrap), bank toggles; else if cpu_req and no ack this cycle -> CPU.
REQ-014 line_req SHALL take priority over a cpu_req arriving in the same cycle.
REQ-015 FETCH: each cycle SHALL issue a read at mem_addr = line base + word and increment word, unless the cycle is a CPU steal.
REQ-016 A CPU steal SHALL occur when cpu_req is high, no cpu_ack is pending this cycle, and CPU_SLOT-1 consecutive fetch reads have been issued; the steal cycle SHALL perform the CPU access, and the consecutive-read count SHALL then reset to 0.
REQ-017 After read word WORDS_PER_LINE-1 is issued, FETCH SHALL return to IDLE; fetch_busy SHALL be high in every cycle in which the FSM is in FETCH.
REQ-018 For each fetch read issued in cycle N, cycle N+1 SHALL have lb_we=1, lb_addr={bank, word}, lb_wdata=mem_rdata.
REQ-019 CPU state/steal: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata; cpu_ack=1 in the next cycle, with cpu_rdata=mem_rdata for reads; CPU state returns to IDLE after one cycle.
REQ-020 No CPU access SHALL be granted in a cycle in which cpu_ack is high, so that the requester can drop cpu_req.
REQ-021 A line_req during FETCH SHALL set underrun and restart the fetch for the new line_num, toggling bank and setting word = 0; the read pipeline stage already in flight SHALL still complete its lb write.
REQ-022 A line_req in the CPU state SHALL be latched and serviced in the following cycle; the CPU access SHALL complete normally.
REQ-023 underrun SHALL stay set until reset.

Reset
REQ-024 reset SHALL force IDLE, bank=0, word=0, slot count=0, and the pending-line latch clear.
REQ-025 reset SHALL force all outputs to 0: mem_*, lb_*, cpu_ack, cpu_rdata, fetch_busy and underrun.
REQ-026 reset during a fetch SHALL abort it with no further lb_we, and SHALL suppress the lb write and cpu_ack of any access issued in the reset cycle.

Verification
REQ-027 line_req, line_num=2, no CPU -> reads at mem_addr 320..479 on 160 consecutive cycles, lb_we at lb_addr {1,0..159}, fetch_busy high for 160 cycles.
REQ-028 cpu_req held during that fetch -> CPU access after every 3 reads, 53 steals max, cpu_ack 1 cycle after each, fetch completes in ≤213 cycles.
REQ-029 CPU write 0xDEADBEEF to addr 5, then read addr 5 with model RAM -> cpu_rdata=0xDEADBEEF, no grant in either ack cycle.
REQ-030 line_req at fetch word 50 -> underrun=1 and persists, new fetch starts at word 0 of new line in bank 0, word-49 lb write still occurs.
REQ-031 line_req and cpu_req in the same IDLE cycle -> fetch first; line_req during CPU state -> FETCH begins next cycle.
REQ-032 reset asserted at fetch word 80 -> next cycle all outputs 0, and the next line_req writes bank 1.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: streams one scanline per line_req into a double-buffered
// line buffer while periodically lending the single-port RAM to the CPU.
module vga_fb_arbiter #(
  parameter int WORDS_PER_LINE = 160,
  parameter int ADDR_W         = 17,
  parameter int FB_BASE        = 0,
  parameter int CPU_SLOT       = 4
) (
  input  logic              pixelClock,
  input  logic              reset,
  input  logic              line_req,
  input  logic [9:0]        line_num,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              lb_we,
  output logic [8:0]        lb_addr,
  output logic [31:0]       lb_wdata,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_CPU   = 2'd2;

  localparam logic [7:0]        LAST_WORD = 8'(WORDS_PER_LINE - 1);
  localparam logic [7:0]        SLOT_MAX  = 8'(CPU_SLOT - 1);
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] WPL       = ADDR_W'(WORDS_PER_LINE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        word_q, word_d;
  logic              bank_q, bank_d;
  logic [7:0]        slot_q, slot_d;
  logic              underrun_q, underrun_d;
  logic              lbv_q;
  logic [8:0]        lb_addr_q;
  logic              ack_q;
  logic              ack_rd_q;

  logic              steal;
  logic              cpu_acc;
  logic              fetch_rd;
  logic              start;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] new_base;

  // The cycle right after a grant carries cpu_ack, so it never grants again.
  assign steal      = (state_q == S_FETCH) && cpu_req && !ack_q && (slot_q >= SLOT_MAX);
  assign cpu_acc    = (state_q == S_CPU) || steal;
  assign fetch_rd   = (state_q == S_FETCH) && !steal;
  assign fetch_addr = base_q + ADDR_W'(word_q);
  assign new_base   = BASE0 + ADDR_W'(line_num) * WPL;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_d     = word_q;
    bank_d     = bank_q;
    slot_d     = slot_q;
    underrun_d = underrun_q;
    start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (line_req) start = 1'b1;
        else if (cpu_req && !ack_q) state_d = S_CPU;
      end
      S_FETCH: begin
        if (line_req) begin
          start      = 1'b1;
          underrun_d = 1'b1;
        end else if (steal) begin
          slot_d = 8'd0;
        end else begin
          word_d = word_q + 8'd1;
          if (slot_q < SLOT_MAX) slot_d = slot_q + 8'd1;
          if (word_q == LAST_WORD) state_d = S_IDLE;
        end
      end
      S_CPU: begin
        if (line_req) start = 1'b1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_FETCH;
      base_d  = new_base;
      word_d  = 8'd0;
      bank_d  = ~bank_q;
      slot_d  = 8'd0;
    end
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= 8'd0;
      bank_q     <= 1'b0;
      slot_q     <= 8'd0;
      underrun_q <= 1'b0;
      lbv_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bank_q     <= bank_d;
      slot_q     <= slot_d;
      underrun_q <= underrun_d;
      lbv_q      <= fetch_rd;
      ack_q      <= cpu_acc;
    end
  end

  // Data-only registers; every consumer is qualified by a reset control flag.
  always_ff @(posedge pixelClock) begin
    base_q    <= base_d;
    lb_addr_q <= {bank_q, word_q};
    ack_rd_q  <= ~cpu_we;
  end

  assign mem_en     = fetch_rd | cpu_acc;
  assign mem_we     = cpu_acc & cpu_we;
  assign mem_addr   = cpu_acc ? cpu_addr : (fetch_rd ? fetch_addr : '0);
  assign mem_wdata  = cpu_acc ? cpu_wdata : '0;
  assign lb_we      = lbv_q;
  assign lb_addr    = lbv_q ? lb_addr_q : '0;
  assign lb_wdata   = lbv_q ? mem_rdata : '0;
  assign cpu_ack    = ack_q;
  assign cpu_rdata  = (ack_q && ack_rd_q) ? mem_rdata : '0;
  assign fetch_busy = (state_q == S_FETCH);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: model RAM, cycle-level behavioural model with a
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_vga_fb_arbiter;
  localparam int W    = 160;
  localparam int AW   = 17;
  localparam int BASE = 0;
  localparam int SLOT = 4;
  localparam int MEMN = 1 << AW;

  logic          pixelClock = 1'b0;
  logic          reset = 1'b1;
  logic          line_req = 1'b0;
  logic [9:0]    line_num = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_ack;
  logic [31:0]   cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          lb_we;
  logic [8:0]    lb_addr;
  logic [31:0]   lb_wdata;
  logic          fetch_busy, underrun;

  always #5 pixelClock = ~pixelClock;

  vga_fb_arbiter #(.WORDS_PER_LINE(W), .ADDR_W(AW), .FB_BASE(BASE), .CPU_SLOT(SLOT)) dut (
    .pixelClock(pixelClock), .reset(reset),
    .line_req(line_req), .line_num(line_num),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .underrun(underrun)
  );

  logic [31:0] ram     [0:MEMN-1];
  logic [31:0] mdl_mem [0:MEMN-1];

  always @(posedge pixelClock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          mv = 0;
  bit          m_fetch = 0, m_cpu = 0, m_bank = 0, m_und = 0;
  bit          m_ack = 0, m_ack_rd = 0, m_lb = 0;
  int          m_line_base = 0, m_word = 0, m_since = 0;
  logic [8:0]  m_lb_addr = '0;
  logic [31:0] m_lb_data = '0, m_ack_data = '0;

  task automatic model_step();
    bit steal, cacc, frd, start;
    int faddr;
    bit n_lb, n_ack, n_ack_rd;
    logic [8:0]  n_lb_addr;
    logic [31:0] n_lb_data, n_ack_data;
    logic [AW-1:0] e_addr;
    steal = m_fetch && cpu_req && !m_ack && (m_since >= SLOT - 1);
    cacc  = m_cpu || steal;
    frd   = m_fetch && !steal;
    faddr = (m_line_base + m_word) % MEMN;
    e_addr = cacc ? cpu_addr : (frd ? AW'(faddr) : '0);
    if (mv) begin
      chk("mem_en", mem_en, cacc | frd);
      chk("mem_we", mem_we, cacc & cpu_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, cacc ? cpu_wdata : 32'd0);
      chk("lb_we", lb_we, m_lb);
      chk("lb_addr", lb_addr, m_lb ? m_lb_addr : 9'd0);
      chk("lb_wdata", lb_wdata, m_lb ? m_lb_data : 32'd0);
      chk("cpu_ack", cpu_ack, m_ack);
      chk("cpu_rdata", cpu_rdata, (m_ack && m_ack_rd) ? m_ack_data : 32'd0);
      chk("fetch_busy", fetch_busy, m_fetch);
      chk("underrun", underrun, m_und);
    end
    n_lb       = frd;
    n_lb_addr  = {m_bank, 8'(m_word)};
    n_lb_data  = mdl_mem[faddr];
    n_ack      = cacc;
    n_ack_rd   = !cpu_we;
    n_ack_data = mdl_mem[cpu_addr];
    if (cacc && cpu_we) mdl_mem[cpu_addr] = cpu_wdata;
    if (reset) begin
      m_fetch = 0; m_cpu = 0; m_bank = 0; m_und = 0;
      m_ack = 0; m_lb = 0; m_word = 0; m_since = 0;
      mv = 1;
    end else begin
      start = 0;
      if (m_cpu) begin
        m_cpu = 0;
        start = line_req;
      end else if (m_fetch) begin
        if (line_req) begin
          m_und = 1;
          start = 1;
        end else if (steal) begin
          m_since = 0;
        end else begin
          m_since++;
          m_word++;
          if (m_word == W) m_fetch = 0;
        end
      end else begin
        if (line_req) start = 1;
        else if (cpu_req && !m_ack) m_cpu = 1;
      end
      if (start) begin
        m_fetch = 1; m_word = 0; m_since = 0; m_bank = !m_bank;
        m_line_base = BASE + int'(line_num) * W;
      end
      m_lb = n_lb; m_lb_addr = n_lb_addr; m_lb_data = n_lb_data;
      m_ack = n_ack; m_ack_rd = n_ack_rd; m_ack_data = n_ack_data;
    end
  endtask

  always @(negedge pixelClock) begin
    #2;
    model_step();
  end

  bit rst_nxt = 1;

  task automatic go(input bit lr, input logic [9:0] ln, input bit cr, input bit cw,
                    input logic [AW-1:0] ca, input logic [31:0] cd);
    @(negedge pixelClock);
    reset = rst_nxt; line_req = lr; line_num = ln;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 10'd0, 0, 0, '0, '0);
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 400; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (!fetch_busy) break;
    end
    chk(nm, fetch_busy, 1'b0);
  endtask

  task automatic cpu_xact(input string nm, input bit we, input logic [AW-1:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
    bit ok;
    ok = 0;
    rd = '0;
    for (int c = 0; c < 20; c++) begin
      go(0, 10'd0, 1, we, a, d);
      if (cpu_ack) begin
        rd = cpu_rdata;
        ok = 1;
        break;
      end
    end
    chk({nm, "_ack"}, ok, 1'b1);
    go(0, 10'd0, 0, 0, '0, '0);
    chk({nm, "_nogrant"}, mem_en, 1'b0);
  endtask

  initial begin
    int nr, nl, nb, steals, since;
    bit ord_ok, ack_ok, slot_ok, prev_acc, seen_a, seen_l, act, rst, lr, busy_last;
    logic [AW-1:0] first_a, last_a, raddr;
    logic [31:0] rd, rdata_r;
    bit rwe;

    for (int i = 0; i < MEMN; i++) begin
      ram[i]     = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      mdl_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    end

    rst_nxt = 1;
    idle(3);
    rst_nxt = 0;
    idle(1);
    chk("rst_outs", {mem_en, lb_we, cpu_ack, fetch_busy, underrun}, 5'd0);

    // Plain line fetch of line 2
    go(1, 10'd2, 0, 0, '0, '0);
    nr = 0; nl = 0; nb = 0; ord_ok = 1; first_a = '0; last_a = '0;
    for (int c = 0; c < 300; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (mem_en && !mem_we) begin
        if (nr == 0) first_a = mem_addr;
        last_a = mem_addr;
        if (int'(mem_addr) != 320 + nr) ord_ok = 0;
        nr++;
      end
      if (lb_we) begin
        if (lb_addr != 9'(256 + nl)) ord_ok = 0;
        nl++;
      end
      if (fetch_busy) nb++;
      if (nl >= 160 && !fetch_busy) break;
    end
    chk("A_reads", nr, 160);
    chk("A_busy", nb, 160);
    chk("A_lbw", nl, 160);
    chk("A_first_addr", first_a, 320);
    chk("A_last_addr", last_a, 479);
    chk("A_order", ord_ok, 1'b1);

    // Same line with the CPU hammering reads at address 7
    go(1, 10'd2, 1, 0, 17'd7, '0);
    steals = 0; nb = 0; since = 0; ack_ok = 1; slot_ok = 1; prev_acc = 0;
    for (int c = 0; c < 400; c++) begin
      go(0, 10'd0, 1, 0, 17'd7, '0);
      if (cpu_ack !== prev_acc) ack_ok = 0;
      prev_acc = mem_en && (mem_addr == 17'd7);
      if (fetch_busy) begin
        nb++;
        if (prev_acc) begin
          steals++;
          if (since != SLOT - 1) slot_ok = 0;
          since = 0;
        end else if (mem_en) begin
          since++;
        end
      end
      if (nb > 0 && !fetch_busy) break;
    end
    chk("B_steals", steals, 53);
    chk("B_busy", nb, 213);
    chk("B_ack_timing", ack_ok, 1'b1);
    chk("B_slot", slot_ok, 1'b1);
    idle(4);

    // CPU write then read back
    cpu_xact("C_wr", 1, 17'd5, 32'hDEADBEEF, rd);
    cpu_xact("C_rd", 0, 17'd5, 32'h0, rd);
    chk("C_rd_data", rd, 32'hDEADBEEF);
    idle(2);

    // Line request interrupting a fetch at word 50
    go(1, 10'd3, 0, 0, '0, '0);
    nr = 0;
    for (int c = 0; c < 100; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (mem_en && !mem_we) nr++;
      if (nr == 50) break;
    end
    go(1, 10'd4, 0, 0, '0, '0);
    chk("D_w49_lb", {lb_we, lb_addr}, {1'b1, 9'h131});
    seen_a = 0; seen_l = 0;
    for (int c = 0; c < 10; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (c == 0) chk("D_underrun", underrun, 1'b1);
      if (mem_en && !mem_we && mem_addr == 17'd640) seen_a = 1;
      if (lb_we && lb_addr == 9'h000) seen_l = 1;
    end
    chk("D_new_addr", seen_a, 1'b1);
    chk("D_bank0_word0", seen_l, 1'b1);
    wait_idle("D_done");
    chk("D_und_persist", underrun, 1'b1);
    idle(3);

    // Priority of line_req, and line_req arriving in the CPU state
    go(1, 10'd5, 1, 0, 17'd9, '0);
    go(0, 10'd0, 0, 0, '0, '0);
    chk("E_fetch_first", {fetch_busy, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 17'd800});
    wait_idle("E_done1");
    idle(3);
    go(0, 10'd0, 1, 0, 17'd9, '0);
    go(1, 10'd6, 1, 0, 17'd9, '0);
    chk("E_cpu_cycle", {mem_en, mem_addr}, {1'b1, 17'd9});
    go(0, 10'd0, 0, 0, '0, '0);
    chk("E_fetch_next", {fetch_busy, cpu_ack, mem_addr}, {1'b1, 1'b1, 17'd960});
    wait_idle("E_done2");
    idle(3);

    // Reset in the middle of a fetch
    go(1, 10'd7, 0, 0, '0, '0);
    nr = 0;
    for (int c = 0; c < 200; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (mem_en && !mem_we) nr++;
      if (nr == 80) break;
    end
    rst_nxt = 1;
    idle(1);
    rst_nxt = 0;
    idle(1);
    chk("F_outs_zero", {mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata,
                        cpu_ack, cpu_rdata, fetch_busy, underrun}, 128'd0);
    nl = 0;
    for (int c = 0; c < 3; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (lb_we) nl++;
    end
    chk("F_no_lbw", nl, 0);
    go(1, 10'd8, 0, 0, '0, '0);
    seen_l = 0;
    for (int c = 0; c < 10; c++) begin
      go(0, 10'd0, 0, 0, '0, '0);
      if (lb_we) begin
        seen_l = lb_addr[8];
        break;
      end
    end
    chk("F_bank1", seen_l, 1'b1);
    wait_idle("F_done");

    // Random traffic against the model
    act = 0; busy_last = 0; rwe = 0; raddr = '0; rdata_r = '0;
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 1999) == 0);
      if (rst) act = 0;
      else if (!act && $urandom_range(0, 3) == 0) begin
        act = 1;
        rwe = 1'($urandom_range(0, 1));
        raddr = AW'($urandom);
        rdata_r = $urandom;
      end
      lr = busy_last ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 24) == 0);
      rst_nxt = rst;
      go(lr, 10'($urandom_range(0, 1023)), act, rwe, raddr, rdata_r);
      if (cpu_ack && act) act = 0;
      busy_last = fetch_busy;
    end
    rst_nxt = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
